// File: rtl/port_responder.sv
// port_responder: CPU port-mapped block with a TX FIFO, an RX holding register and an LED latch.
// Accesses fire only on the rising edge of portget/portset; a write wins over a simultaneous read.
module port_responder #(
  parameter int                   WORD_SIZE  = 16,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR  = 16'h0010,
  parameter int                   FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 do_reset_n,
  input  logic [WORD_SIZE-1:0] portaddr,
  input  logic [WORD_SIZE-1:0] portval,
  input  logic                 portget,
  input  logic                 portset,
  output logic [WORD_SIZE-1:0] portout,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [WORD_SIZE-1:0] rx_data,
  input  logic                 rx_strobe,
  output logic [WORD_SIZE-1:0] leds
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [4:0] count;
  logic get_d, set_d, tx_ovf, rx_ovr, rx_valid;
  logic [WORD_SIZE-1:0] rx_hold, off, status, rd_val;
  logic wr, rd, pop, push_req, push, rx_clr, stat_wr;
  assign tx_valid = count != 5'd0;
  assign tx_data  = mem[rptr];
  always_comb begin
    off      = portaddr - BASE_ADDR;
    wr       = portset & ~set_d;
    rd       = portget & ~get_d & ~wr;
    pop      = tx_valid & tx_ready;
    push_req = wr && off == '0;
    push     = push_req && (count < 5'(FIFO_DEPTH) || pop);
    stat_wr  = wr && off == WORD_SIZE'(1);
    rx_clr   = rd && off == WORD_SIZE'(2);
    status   = WORD_SIZE'({count, rx_ovr, tx_ovf, rx_valid, count == 5'(FIFO_DEPTH), count == 5'd0});
    rd_val   = off == WORD_SIZE'(1) ? status :
               off == WORD_SIZE'(2) ? rx_hold :
               off == WORD_SIZE'(3) ? leds : '0;
  end
  always_ff @(posedge clk or negedge do_reset_n)
    if (!do_reset_n) begin
      get_d    <= 1'b0;
      set_d    <= 1'b0;
      portout  <= '0;
      leds     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      tx_ovf   <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_valid <= 1'b0;
      rx_hold  <= '0;
    end else begin
      get_d <= portget;
      set_d <= portset;
      if (rd) portout <= rd_val;
      if (wr && off == WORD_SIZE'(3)) leds <= portval;
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count    <= count + 5'(push) - 5'(pop);
      tx_ovf   <= (tx_ovf & ~(stat_wr & portval[3])) | (push_req & ~push);
      // a RXDATA read in the same cycle consumes the old word, so the new one is not an overrun
      rx_ovr   <= (rx_ovr & ~(stat_wr & portval[4])) | (rx_strobe & rx_valid & ~rx_clr);
      rx_valid <= rx_strobe | (rx_valid & ~rx_clr);
      if (rx_strobe) rx_hold <= rx_data;
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= portval;
endmodule

// File: tb/tb_port_responder.sv
// tb_port_responder: directed and random stimulus against a queue-based reference model,
// with a monitor that scores read data, LED state and the TX stream.
module tb_port_responder;
  localparam logic [15:0] BASE = 16'h0010;
  localparam int DEPTH = 4;
  logic clk = 1'b0, do_reset_n = 1'b0;
  logic [15:0] portaddr = '0, portval = '0, rx_data = '0;
  logic portget = 1'b0, portset = 1'b0, tx_ready = 1'b0, rx_strobe = 1'b0;
  logic [15:0] portout, tx_data, leds;
  logic tx_valid;
  int passed = 0, total = 0;

  port_responder dut (
    .clk(clk), .do_reset_n(do_reset_n), .portaddr(portaddr), .portval(portval),
    .portget(portget), .portset(portset), .portout(portout), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // reference model: FIFO as a queue, registers as plain variables
  logic [15:0] m_fifo[$], exp_tx[$], rd_q[$];
  logic [15:0] m_leds, m_portout, m_rxh, m_off, m_st;
  logic m_rxv, m_txo, m_rxo, m_pg, m_ps, m_wr, m_rd, m_pop, m_clr;
  int m_n;

  always @(posedge clk or negedge do_reset_n)
    if (!do_reset_n) begin
      m_fifo.delete(); exp_tx.delete(); rd_q.delete();
      m_leds = 0; m_portout = 0; m_rxh = 0;
      m_rxv = 0; m_txo = 0; m_rxo = 0; m_pg = 0; m_ps = 0;
    end else begin
      m_wr = portset && !m_ps;
      m_rd = portget && !m_pg && !m_wr;
      m_ps = portset;
      m_pg = portget;
      m_off = portaddr - BASE;
      m_n = m_fifo.size();
      m_st = 16'(m_n << 5) | 16'({m_rxo, m_txo, m_rxv, m_n == DEPTH, m_n == 0});
      m_pop = m_n > 0 && tx_ready;
      m_clr = m_rd && m_off == 16'd2;
      if (m_pop) void'(m_fifo.pop_front());
      if (m_wr && m_off == 16'd0) begin
        if (m_n < DEPTH || m_pop) begin
          m_fifo.push_back(portval);
          exp_tx.push_back(portval);
        end else m_txo = 1;
      end
      if (m_wr && m_off == 16'd1) begin
        if (portval[3]) m_txo = 0;
        if (portval[4]) m_rxo = 0;
      end
      if (m_wr && m_off == 16'd3) m_leds = portval;
      if (m_rd) begin
        m_portout = m_off == 16'd1 ? m_st : m_off == 16'd2 ? m_rxh : m_off == 16'd3 ? m_leds : 16'h0;
        rd_q.push_back(m_portout);
      end
      if (rx_strobe) begin
        if (m_rxv && !m_clr) m_rxo = 1;
        m_rxh = rx_data;
        m_rxv = 1;
      end else if (m_clr) m_rxv = 0;
    end

  // monitor: inputs change at negedge, so negedge+2 sees both settled outputs and the ready used next edge
  always @(negedge clk) begin
    #2;
    if (rd_q.size() > 0) chk("read_data", portout, rd_q.pop_front());
    chk("portout_hold", portout, m_portout);
    chk("leds", leds, m_leds);
    chk("tx_valid", 16'(tx_valid), 16'(m_fifo.size() != 0));
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) chk("tx_extra_word", 16'(exp_tx.size()), 16'd1);
      else chk("tx_data", tx_data, exp_tx.pop_front());
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] v, input logic g, input logic s,
                       input logic r, input logic rs, input logic [15:0] rd);
    @(negedge clk);
    portaddr = a; portval = v; portget = g; portset = s;
    tx_ready = r; rx_strobe = rs; rx_data = rd;
  endtask
  task automatic idle(input logic r);
    drive(BASE, 16'h0, 1'b0, 1'b0, r, 1'b0, 16'h0);
  endtask
  task automatic wr_port(input logic [15:0] a, input logic [15:0] v, input logic r);
    drive(a, v, 1'b0, 1'b1, r, 1'b0, 16'h0);
    idle(r);
  endtask
  task automatic rd_port(input logic [15:0] a, input logic r);
    drive(a, 16'h0, 1'b1, 1'b0, r, 1'b0, 16'h0);
    idle(r);
  endtask

  initial begin
    repeat (3) idle(1'b0);
    chk("reset_portout", portout, 16'h0);
    chk("reset_leds", leds, 16'h0);
    chk("reset_tx_valid", 16'(tx_valid), 16'h0);
    do_reset_n = 1'b1;
    idle(1'b0);
    wr_port(16'h0013, 16'hA5A5, 1'b0);
    rd_port(16'h0013, 1'b0);
    chk("leds_A5A5", leds, 16'hA5A5);
    chk("read_leds", portout, 16'hA5A5);
    for (int i = 1; i <= 5; i++) wr_port(BASE, 16'(i), 1'b0);
    rd_port(BASE + 16'd1, 1'b0);
    chk("status_full_ovf", portout, 16'h008A);
    repeat (6) idle(1'b1);
    chk("drained_tx_valid", 16'(tx_valid), 16'h0);
    wr_port(BASE + 16'd1, 16'h0008, 1'b0);
    repeat (3) drive(BASE, 16'h0077, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    idle(1'b0);
    rd_port(BASE + 16'd1, 1'b0);
    chk("held_set_one_push", portout, 16'h0020);
    repeat (3) idle(1'b1);
    drive(BASE, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111);
    idle(1'b1);
    drive(BASE, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222);
    idle(1'b1);
    rd_port(BASE + 16'd1, 1'b1);
    chk("status_overrun", portout, 16'h0015);
    rd_port(BASE + 16'd2, 1'b1);
    chk("rxdata_latest", portout, 16'h2222);
    rd_port(BASE + 16'd1, 1'b1);
    chk("status_rx_cleared", portout, 16'h0011);
    wr_port(BASE + 16'd1, 16'h0010, 1'b1);
    rd_port(BASE + 16'd1, 1'b1);
    chk("status_overrun_clr", portout, 16'h0001);
    drive(BASE, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3333);
    drive(BASE + 16'd2, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4444);
    idle(1'b1);
    chk("rx_read_vs_strobe", portout, 16'h3333);
    rd_port(BASE + 16'd1, 1'b1);
    chk("status_no_overrun", portout, 16'h0005);
    rd_port(BASE + 16'd2, 1'b1);
    chk("rx_new_word", portout, 16'h4444);
    drive(16'h0013, 16'h5A5A, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    idle(1'b0);
    chk("get_set_write_wins", leds, 16'h5A5A);
    chk("get_set_no_read", portout, 16'h4444);
    for (int i = 0; i < DEPTH; i++) wr_port(BASE, 16'h0010 + 16'(i), 1'b0);
    drive(BASE, 16'h0099, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    idle(1'b0);
    rd_port(BASE + 16'd1, 1'b0);
    chk("full_push_pop", portout, 16'h0082);
    repeat (6) idle(1'b1);
    rd_port(16'h0020, 1'b0);
    chk("unmapped_read", portout, 16'h0);
    rd_port(16'h0013, 1'b0);
    rd_port(16'h000F, 1'b0);
    chk("wrapped_offset_read", portout, 16'h0);
    for (int i = 0; i < 3; i++) wr_port(BASE, 16'h0A00 + 16'(i), 1'b0);
    wr_port(16'h0013, 16'hBEEF, 1'b0);
    rd_port(16'h0013, 1'b0);
    @(posedge clk);
    #3 do_reset_n = 1'b0;
    #1;
    chk("async_rst_tx_valid", 16'(tx_valid), 16'h0);
    chk("async_rst_leds", leds, 16'h0);
    chk("async_rst_portout", portout, 16'h0);
    drive(16'h0013, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    do_reset_n = 1'b1;
    idle(1'b0);
    chk("held_set_after_reset", leds, 16'h1234);
    chk("fifo_discarded", 16'(tx_valid), 16'h0);
    repeat (1500)
      drive(($urandom % 8 == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 4)), 16'($urandom),
            $urandom % 3 == 0, $urandom % 4 == 0, $urandom % 2 == 0, $urandom % 5 == 0, 16'($urandom));
    repeat (10) idle(1'b1);
    chk("tx_all_delivered", 16'(exp_tx.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
